// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared mode encodings and counter limits for the alarm clock
package alarm_clock_pkg;
  localparam int MIN_W   = 6;
  localparam int HR_W    = 5;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;
  typedef enum logic [2:0] {
    MODE_RUN      = 3'd0,
    MODE_SET_HR   = 3'd1,
    MODE_SET_MIN  = 3'd2,
    MODE_SET_AHR  = 3'd3,
    MODE_SET_AMIN = 3'd4
  } mode_e;
  function automatic mode_e next_mode(input mode_e m);
    return (m == MODE_SET_AMIN) ? MODE_RUN : mode_e'(m + 3'd1);
  endfunction
endpackage

// File: rtl/alarm_ringer.sv
// alarm_ringer: alarm compare, buzzer flag, ring timeout and button cancel
module alarm_ringer #(
  parameter int MIN_W     = 6,
  parameter int HR_W      = 5,
  parameter int RING_SECS = 60
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             any_btn,
  input  logic             arm_ok,
  input  logic [MIN_W-1:0] sec,
  input  logic [MIN_W-1:0] min,
  input  logic [HR_W-1:0]  hr,
  input  logic [MIN_W-1:0] amin,
  input  logic [HR_W-1:0]  ahr,
  output logic             buzzer
);
  logic       buzz_q, buzz_d, fire, done;
  logic [7:0] ring_q, ring_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      buzz_q <= 1'b0;
      ring_q <= '0;
    end else begin
      buzz_q <= buzz_d;
      ring_q <= ring_d;
    end
  end
  // the ring counter only runs while sounding; the final tick clears both flag and count
  always_comb begin
    fire   = arm_ok && tick_1hz && sec == '0 && min == amin && hr == ahr;
    done   = tick_1hz && ring_q == 8'(RING_SECS - 1);
    buzz_d = buzz_q ? !(any_btn || done) : fire;
    ring_d = (buzz_q && !any_btn && !done) ? ring_q + 8'(tick_1hz) : '0;
  end
  assign buzzer = buzz_q;
endmodule

// File: rtl/alarm_clock_ctrl.sv
// alarm_clock_ctrl: mode FSM, button arbitration and counter strobe decode
module alarm_clock_ctrl import alarm_clock_pkg::*; #(
  parameter int SEC_MAX   = alarm_clock_pkg::SEC_MAX,
  parameter int MIN_MAX   = alarm_clock_pkg::MIN_MAX,
  parameter int HR_W      = alarm_clock_pkg::HR_W,
  parameter int MIN_W     = alarm_clock_pkg::MIN_W,
  parameter int RING_SECS = 60
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_center,
  input  logic [MIN_W-1:0] sec,
  input  logic [MIN_W-1:0] min,
  input  logic [HR_W-1:0]  hr,
  input  logic [MIN_W-1:0] amin,
  input  logic [HR_W-1:0]  ahr,
  output logic             sec_en,
  output logic             sec_load,
  output logic             min_en,
  output logic             min_cd,
  output logic             hr_en,
  output logic             hr_cd,
  output logic             amin_en,
  output logic             amin_cd,
  output logic             ahr_en,
  output logic             ahr_cd,
  output logic [2:0]       mode,
  output logic             alarm_armed,
  output logic             buzzer
);
  mode_e mode_q, mode_d;
  logic  armed_q, armed_d, run, btn_ok, adj, sec_wrap, min_wrap;
  assign run    = mode_q == MODE_RUN;
  assign btn_ok = !buzzer;
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_RUN;
      armed_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      armed_q <= armed_d;
    end
  end
  always_comb begin
    mode_d  = (btn_mode && btn_ok) ? next_mode(mode_q) : mode_q;
    armed_d = armed_q ^ (run && btn_ok && btn_center && !btn_mode);
  end
  // up/down act only when neither a higher-priority button nor the ringer claims the cycle
  always_comb begin
    sec_wrap = tick_1hz && sec == MIN_W'(SEC_MAX);
    min_wrap = sec_wrap && min == MIN_W'(MIN_MAX);
    adj      = !reset && btn_ok && !btn_mode && !btn_center && (btn_up ^ btn_down);
    sec_en   = !reset && run && tick_1hz;
    sec_load = !reset && run && btn_ok && btn_mode;
    min_en   = !reset && (run ? sec_wrap : mode_q == MODE_SET_MIN && adj);
    hr_en    = !reset && (run ? min_wrap : mode_q == MODE_SET_HR && adj);
    amin_en  = mode_q == MODE_SET_AMIN && adj;
    ahr_en   = mode_q == MODE_SET_AHR && adj;
    min_cd   = mode_q == MODE_SET_MIN && adj && btn_down;
    hr_cd    = mode_q == MODE_SET_HR && adj && btn_down;
    amin_cd  = mode_q == MODE_SET_AMIN && adj && btn_down;
    ahr_cd   = mode_q == MODE_SET_AHR && adj && btn_down;
  end
  assign mode        = mode_q;
  assign alarm_armed = armed_q;
  alarm_ringer #(.MIN_W(MIN_W), .HR_W(HR_W), .RING_SECS(RING_SECS)) u_ringer (
    .clk      (clk),
    .reset    (reset),
    .tick_1hz (tick_1hz),
    .any_btn  (btn_mode || btn_up || btn_down || btn_center),
    .arm_ok   (run && armed_q && !btn_mode),
    .sec      (sec),
    .min      (min),
    .hr       (hr),
    .amin     (amin),
    .ahr      (ahr),
    .buzzer   (buzzer)
  );
endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// tb_alarm_clock_ctrl: directed and random stimulus checked against a behavioural alarm clock model
module tb_alarm_clock_ctrl;
  logic       clk = 1'b0, reset = 1'b1, tick_1hz = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_center = 1'b0;
  logic [5:0] sec = '0, min = '0, amin = '0;
  logic [4:0] hr = '0, ahr = '0;
  logic       sec_en, sec_load, min_en, min_cd, hr_en, hr_cd, amin_en, amin_cd, ahr_en, ahr_cd;
  logic [2:0] mode;
  logic       alarm_armed, buzzer;
  int checks = 0, errors = 0;
  int m_mode = 0, m_ring = 0;
  bit m_armed = 0, m_buzz = 0;
  int fld [5] = '{0, 2, 1, 4, 3};

  alarm_clock_ctrl dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_center(btn_center),
    .sec(sec), .min(min), .hr(hr), .amin(amin), .ahr(ahr),
    .sec_en(sec_en), .sec_load(sec_load), .min_en(min_en), .min_cd(min_cd),
    .hr_en(hr_en), .hr_cd(hr_cd), .amin_en(amin_en), .amin_cd(amin_cd),
    .ahr_en(ahr_en), .ahr_cd(ahr_cd), .mode(mode), .alarm_armed(alarm_armed), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: apply inputs, compare against the model, then advance the model at the edge
  task automatic step(input bit t, input bit bm, input bit bu, input bit bd, input bit bc, input bit rs);
    bit [4:0] e_en, e_cd;
    bit ok, adj, trig;
    reset = rs; tick_1hz = t; btn_mode = bm; btn_up = bu; btn_down = bd; btn_center = bc;
    #1;
    e_en = '0; e_cd = '0;
    ok  = !rs && !m_buzz;
    adj = ok && !bm && !bc && (bu != bd);
    if (!rs && m_mode == 0) begin
      e_en[0] = t;
      e_en[1] = t && sec == 59;
      e_en[2] = e_en[1] && min == 59;
    end else if (adj) begin
      e_en[fld[m_mode]] = 1'b1;
      e_cd[fld[m_mode]] = bd;
    end
    chk("sec_en", 8'(sec_en), 8'(e_en[0]));
    chk("sec_load", 8'(sec_load), 8'(ok && m_mode == 0 && bm));
    chk("min_en", 8'(min_en), 8'(e_en[1]));
    chk("min_cd", 8'(min_cd), 8'(e_cd[1]));
    chk("hr_en", 8'(hr_en), 8'(e_en[2]));
    chk("hr_cd", 8'(hr_cd), 8'(e_cd[2]));
    chk("amin_en", 8'(amin_en), 8'(e_en[3]));
    chk("amin_cd", 8'(amin_cd), 8'(e_cd[3]));
    chk("ahr_en", 8'(ahr_en), 8'(e_en[4]));
    chk("ahr_cd", 8'(ahr_cd), 8'(e_cd[4]));
    chk("mode", 8'(mode), 8'(m_mode));
    chk("alarm_armed", 8'(alarm_armed), 8'(m_armed));
    chk("buzzer", 8'(buzzer), 8'(m_buzz));
    trig = m_mode == 0 && m_armed && !m_buzz && t && !bm && hr == ahr && min == amin && sec == 0;
    @(posedge clk);
    if (rs) begin
      m_mode = 0; m_armed = 0; m_buzz = 0; m_ring = 0;
    end else if (m_buzz && (bm || bu || bd || bc)) begin
      m_buzz = 0; m_ring = 0;
    end else begin
      if (m_buzz && t) begin
        m_ring++;
        if (m_ring == 60) begin m_buzz = 0; m_ring = 0; end
      end
      if (trig) begin m_buzz = 1; m_ring = 0; end
      if (bm) m_mode = (m_mode + 1) % 5;
      else if (bc && m_mode == 0) m_armed = !m_armed;
    end
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    sec = 6'd5;
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    sec = 6'd59; min = 6'd59; hr = 5'd23;
    step(1, 0, 0, 0, 0, 0);
    sec = 6'd10;
    step(0, 1, 0, 0, 0, 0);
    chk("mode_after_press", 8'(mode), 8'd1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 2; i <= 4; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("mode_seq", 8'(mode), 8'(i));
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
    end
    step(0, 1, 1, 0, 0, 0);
    chk("mode_wrap", 8'(mode), 8'd0);
    hr = 5'd7; ahr = 5'd7; min = 6'd30; amin = 6'd30; sec = 6'd0;
    step(0, 0, 0, 0, 1, 0);
    chk("armed_on", 8'(alarm_armed), 8'd1);
    step(1, 0, 0, 0, 0, 0);
    chk("ring_start", 8'(buzzer), 8'd1);
    sec = 6'd1;
    for (int i = 0; i < 59; i++) step(1, 0, 0, 0, 0, 0);
    chk("ring_59", 8'(buzzer), 8'd1);
    step(1, 0, 0, 0, 0, 0);
    chk("ring_timeout", 8'(buzzer), 8'd0);
    sec = 6'd0;
    step(1, 0, 0, 0, 0, 0);
    chk("ring_again", 8'(buzzer), 8'd1);
    step(0, 1, 0, 0, 0, 0);
    chk("cancel_buzz", 8'(buzzer), 8'd0);
    chk("cancel_mode", 8'(mode), 8'd0);
    step(0, 0, 0, 0, 1, 0);
    chk("armed_off", 8'(alarm_armed), 8'd0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 3);
      sec = r == 0 ? 6'd0 : r == 1 ? 6'd59 : 6'($urandom_range(0, 59));
      r = $urandom_range(0, 3);
      min = r == 0 ? 6'd30 : r == 1 ? 6'd59 : 6'($urandom_range(0, 59));
      r = $urandom_range(0, 3);
      hr = r == 0 ? 5'd7 : r == 1 ? 5'd23 : 5'($urandom_range(0, 23));
      amin = $urandom_range(0, 7) == 0 ? 6'($urandom_range(0, 59)) : 6'd30;
      ahr = $urandom_range(0, 7) == 0 ? 5'($urandom_range(0, 23)) : 5'd7;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
